commit_flush_ctrl: RTL
======================

Name: commit_flush_ctrl

Overview:
Sequences pipeline recovery after the reorder buffer retires a flush-causing instruction: exception, ertn, branch mispredict, priv/ibar/icacop flush, or idle.
Sits between the ROB commit port and the frontend, CSR unit and global flush net.
Selects the cause, computes the redirect target, holds the global flush for a fixed drain window, then hands the redirect to the frontend over a valid/ready handshake.
Parks in a wait state on idle until an interrupt is pending.

Parameters:
COMMIT_WIDTH, 2, number of commit slots examined per cycle
PC_WIDTH, 32, program counter width
FLUSH_CYCLES, 2, cycles flush_o is held high (must be >= 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmt_valid_i  in  COMMIT_WIDTH  per-slot commit valid from ROB
cmt_excp_i  in  COMMIT_WIDTH  slot carries a valid exception
cmt_ertn_i  in  COMMIT_WIDTH  slot is ertn
cmt_redirect_i  in  COMMIT_WIDTH  slot is a mispredicted branch
cmt_flush_i  in  COMMIT_WIDTH  slot needs priv/ibar/icacop flush
cmt_idle_i  in  COMMIT_WIDTH  slot is idle
cmt_pc_i  in  COMMIT_WIDTH x PC_WIDTH  slot PC
cmt_br_target_i  in  COMMIT_WIDTH x PC_WIDTH  resolved branch target
excp_entry_i  in  PC_WIDTH  exception entry from CSR
era_i  in  PC_WIDTH  return address from CSR
int_pending_i  in  1  interrupt pending (idle wake)
redirect_ready_i  in  1  frontend accepts redirect
flush_o  out  1  global pipeline flush
commit_block_o  out  1  ROB must not retire while high
excp_commit_o  out  1  one-cycle pulse to CSR: take exception
excp_pc_o  out  PC_WIDTH  faulting PC for CSR era
ertn_commit_o  out  1  one-cycle pulse to CSR: restore from ertn
redirect_valid_o  out  1  redirect request to frontend
redirect_pc_o  out  PC_WIDTH  redirect target
busy_o  out  1  state != RUN

Behaviour:
- Reset: asynchronous to RUN. All outputs 0, counter 0, latched target 0. Reset mid-sequence abandons the sequence with no redirect issued.
- Trigger: in RUN, the lowest-index slot i where cmt_valid_i[i] and any cause bit is set. Higher slots are ignored in that cycle.
- Cause priority within a slot: excp > ertn > redirect > flush > idle.
- Target, by cause:
  - excp: excp_entry_i.
  - ertn: era_i.
  - redirect: cmt_br_target_i[i].
  - flush, idle: cmt_pc_i[i] + 4, modulo 2^PC_WIDTH (wrap, no carry out).
  - The target is latched at the trigger edge.
- Pulses: excp_commit_o (with excp_pc_o = cmt_pc_i[i]) or ertn_commit_o is asserted for exactly the cycle after the trigger.
- RUN -> FLUSH on trigger (registered).
  - FLUSH: flush_o = 1 and commit_block_o = 1. The counter loads FLUSH_CYCLES-1 and decrements.
  - At counter 0: idle cause -> IDLE_WAIT, else -> REDIRECT. flush_o is high for exactly FLUSH_CYCLES cycles.
- IDLE_WAIT: commit_block_o = 1, flush_o = 0. When int_pending_i = 1, move to REDIRECT next cycle. int_pending_i already high on entry gives one cycle in IDLE_WAIT.
- REDIRECT: redirect_valid_o = 1 with redirect_pc_o stable until redirect_ready_i.
  - Ready in the first REDIRECT cycle completes that cycle, back to RUN next cycle.
  - The ready signal is ignored outside REDIRECT.
- commit_block_o = 1 in every state except RUN. All cmt_* inputs are ignored outside RUN.
- busy_o = 1 in every state except RUN.
- redirect_valid_o = 0 and redirect_pc_o = 0 outside REDIRECT.
- With no trigger, RUN holds every output at 0.
- Minimum trigger-to-redirect latency: 1 + FLUSH_CYCLES cycles.

Decomposition:
- Shared package holds:
  - state enum {RUN, FLUSH, IDLE_WAIT, REDIRECT};
  - cause enum {CAUSE_NONE, CAUSE_EXCP, CAUSE_ERTN, CAUSE_BR, CAUSE_FLUSH, CAUSE_IDLE};
  - the PC increment constant 4.
- One combinational sub-module, flush_cause_sel: slot scan plus priority encode, producing cause, slot index and target.
- The top level holds the FSM, counter and latches.

Test Plan:
- Slot0 excp, pc=0x1c000100, excp_entry=0x1c008000 -> excp_commit_o pulse at T+1 with excp_pc_o=0x1c000100. flush_o high T+1..T+2. redirect_valid_o at T+3 with pc 0x1c008000. ready at T+3 -> RUN at T+4.
- Slot0 plain commit, slot1 redirect with target 0x1c000200 -> FLUSH then REDIRECT pc 0x1c000200. excp_commit_o and ertn_commit_o stay 0.
- Slot0 with ertn and flush both set, era=0x1c000040 -> ertn cause wins. ertn_commit_o pulse, redirect_pc_o=0x1c000040.
- Idle at pc=0xfffffffc, int_pending_i held 0 for 5 cycles then 1 -> commit_block_o held throughout. redirect_pc_o=0x00000000 (wrap).
- redirect_ready_i held 0 for 3 REDIRECT cycles -> valid and pc stable, no state change. New cmt_excp_i during FLUSH is ignored.
- rst_n low mid-FLUSH -> all outputs 0 immediately, state RUN, no redirect issued after release.

Source files
------------

// File: rtl/commit_flush_ctrl_pkg.sv
// Shared types and constants for the commit-flush recovery sequencer.
// Holds the FSM state codes, the flush cause encoding and the PC step.
package commit_flush_ctrl_pkg;

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_FLUSH     = 2'd1;
  localparam logic [1:0] ST_IDLE_WAIT = 2'd2;
  localparam logic [1:0] ST_REDIRECT  = 2'd3;

  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_EXCP,
    CAUSE_ERTN,
    CAUSE_BR,
    CAUSE_FLUSH,
    CAUSE_IDLE
  } cause_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/commit_flush_ctrl_if.sv
// Bundle of ROB commit, CSR and frontend redirect signals around the flush sequencer.
// The master side drives the commit/CSR/ready inputs; the slave side is the sequencer.
interface commit_flush_ctrl_if #(
  parameter int COMMIT_WIDTH = 2,
  parameter int PC_WIDTH     = 32
);
  logic [COMMIT_WIDTH-1:0]               cmt_valid_i;
  logic [COMMIT_WIDTH-1:0]               cmt_excp_i;
  logic [COMMIT_WIDTH-1:0]               cmt_ertn_i;
  logic [COMMIT_WIDTH-1:0]               cmt_redirect_i;
  logic [COMMIT_WIDTH-1:0]               cmt_flush_i;
  logic [COMMIT_WIDTH-1:0]               cmt_idle_i;
  logic [COMMIT_WIDTH-1:0][PC_WIDTH-1:0] cmt_pc_i;
  logic [COMMIT_WIDTH-1:0][PC_WIDTH-1:0] cmt_br_target_i;
  logic [PC_WIDTH-1:0]                   excp_entry_i;
  logic [PC_WIDTH-1:0]                   era_i;
  logic                                  int_pending_i;
  logic                                  redirect_ready_i;
  logic                                  flush_o;
  logic                                  commit_block_o;
  logic                                  excp_commit_o;
  logic [PC_WIDTH-1:0]                   excp_pc_o;
  logic                                  ertn_commit_o;
  logic                                  redirect_valid_o;
  logic [PC_WIDTH-1:0]                   redirect_pc_o;
  logic                                  busy_o;

  modport master (
    output cmt_valid_i, cmt_excp_i, cmt_ertn_i, cmt_redirect_i, cmt_flush_i, cmt_idle_i,
    output cmt_pc_i, cmt_br_target_i, excp_entry_i, era_i, int_pending_i, redirect_ready_i,
    input  flush_o, commit_block_o, excp_commit_o, excp_pc_o, ertn_commit_o,
    input  redirect_valid_o, redirect_pc_o, busy_o
  );

  modport slave (
    input  cmt_valid_i, cmt_excp_i, cmt_ertn_i, cmt_redirect_i, cmt_flush_i, cmt_idle_i,
    input  cmt_pc_i, cmt_br_target_i, excp_entry_i, era_i, int_pending_i, redirect_ready_i,
    output flush_o, commit_block_o, excp_commit_o, excp_pc_o, ertn_commit_o,
    output redirect_valid_o, redirect_pc_o, busy_o
  );
endinterface

// File: rtl/flush_cause_sel.sv
// Combinational slot scan: picks the lowest-index committing slot with a flush cause,
// priority-encodes its cause and computes the redirect target.
module flush_cause_sel
  import commit_flush_ctrl_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int PC_WIDTH     = 32,
  localparam int SLOT_W      = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
  input  logic [COMMIT_WIDTH-1:0]               cmt_valid_i,
  input  logic [COMMIT_WIDTH-1:0]               cmt_excp_i,
  input  logic [COMMIT_WIDTH-1:0]               cmt_ertn_i,
  input  logic [COMMIT_WIDTH-1:0]               cmt_redirect_i,
  input  logic [COMMIT_WIDTH-1:0]               cmt_flush_i,
  input  logic [COMMIT_WIDTH-1:0]               cmt_idle_i,
  input  logic [COMMIT_WIDTH-1:0][PC_WIDTH-1:0] cmt_pc_i,
  input  logic [COMMIT_WIDTH-1:0][PC_WIDTH-1:0] cmt_br_target_i,
  input  logic [PC_WIDTH-1:0]                   excp_entry_i,
  input  logic [PC_WIDTH-1:0]                   era_i,
  output cause_e                                cause_o,
  output logic [SLOT_W-1:0]                     slot_o,
  output logic [PC_WIDTH-1:0]                   target_o
);

  // Scan from the top slot down so the lowest qualifying index is written last and wins.
  always_comb begin
    cause_o  = CAUSE_NONE;
    slot_o   = '0;
    target_o = '0;
    for (int i = COMMIT_WIDTH - 1; i >= 0; i--) begin
      if (cmt_valid_i[i] && (cmt_excp_i[i] || cmt_ertn_i[i] || cmt_redirect_i[i] ||
                             cmt_flush_i[i] || cmt_idle_i[i])) begin
        slot_o = SLOT_W'(i);
        if (cmt_excp_i[i]) begin
          cause_o  = CAUSE_EXCP;
          target_o = excp_entry_i;
        end else if (cmt_ertn_i[i]) begin
          cause_o  = CAUSE_ERTN;
          target_o = era_i;
        end else if (cmt_redirect_i[i]) begin
          cause_o  = CAUSE_BR;
          target_o = cmt_br_target_i[i];
        end else if (cmt_flush_i[i]) begin
          cause_o  = CAUSE_FLUSH;
          target_o = cmt_pc_i[i] + PC_WIDTH'(PC_INC);
        end else begin
          cause_o  = CAUSE_IDLE;
          target_o = cmt_pc_i[i] + PC_WIDTH'(PC_INC);
        end
      end
    end
  end

endmodule

// File: rtl/commit_flush_ctrl.sv
// Pipeline recovery sequencer: on a flush-causing commit, drains the pipeline for a
// fixed window, optionally parks until an interrupt wakes an idle, then redirects the frontend.
module commit_flush_ctrl
  import commit_flush_ctrl_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int PC_WIDTH     = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  commit_flush_ctrl_if.slave bus
);

  localparam int SLOT_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;
  localparam int CNT_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

  cause_e                sel_cause;
  logic [SLOT_W-1:0]     sel_slot;
  logic [PC_WIDTH-1:0]   sel_target;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  cause_e                cause_q, cause_d;
  logic [PC_WIDTH-1:0]   target_q, target_d;
  logic                  excp_commit_q, excp_commit_d;
  logic                  ertn_commit_q, ertn_commit_d;
  logic [PC_WIDTH-1:0]   excp_pc_q, excp_pc_d;

  flush_cause_sel #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .PC_WIDTH     (PC_WIDTH)
  ) u_sel (
    .cmt_valid_i     (bus.cmt_valid_i),
    .cmt_excp_i      (bus.cmt_excp_i),
    .cmt_ertn_i      (bus.cmt_ertn_i),
    .cmt_redirect_i  (bus.cmt_redirect_i),
    .cmt_flush_i     (bus.cmt_flush_i),
    .cmt_idle_i      (bus.cmt_idle_i),
    .cmt_pc_i        (bus.cmt_pc_i),
    .cmt_br_target_i (bus.cmt_br_target_i),
    .excp_entry_i    (bus.excp_entry_i),
    .era_i           (bus.era_i),
    .cause_o         (sel_cause),
    .slot_o          (sel_slot),
    .target_o        (sel_target)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cause_d       = cause_q;
    target_d      = target_q;
    excp_commit_d = 1'b0;
    ertn_commit_d = 1'b0;
    excp_pc_d     = '0;
    case (state_q)
      ST_RUN: begin
        if (sel_cause != CAUSE_NONE) begin
          state_d       = ST_FLUSH;
          cnt_d         = CNT_INIT;
          cause_d       = sel_cause;
          target_d      = sel_target;
          excp_commit_d = (sel_cause == CAUSE_EXCP);
          ertn_commit_d = (sel_cause == CAUSE_ERTN);
          if (sel_cause == CAUSE_EXCP) excp_pc_d = bus.cmt_pc_i[sel_slot];
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = (cause_q == CAUSE_IDLE) ? ST_IDLE_WAIT : ST_REDIRECT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_IDLE_WAIT: begin
        if (bus.int_pending_i) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (bus.redirect_ready_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      cause_q       <= CAUSE_NONE;
      target_q      <= '0;
      excp_commit_q <= 1'b0;
      ertn_commit_q <= 1'b0;
      excp_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cause_q       <= cause_d;
      target_q      <= target_d;
      excp_commit_q <= excp_commit_d;
      ertn_commit_q <= ertn_commit_d;
      excp_pc_q     <= excp_pc_d;
    end
  end

  // Redirect address is gated so the frontend sees zero whenever no request is up.
  assign bus.flush_o          = (state_q == ST_FLUSH);
  assign bus.commit_block_o   = (state_q != ST_RUN);
  assign bus.busy_o           = (state_q != ST_RUN);
  assign bus.redirect_valid_o = (state_q == ST_REDIRECT);
  assign bus.redirect_pc_o    = (state_q == ST_REDIRECT) ? target_q : '0;
  assign bus.excp_commit_o    = excp_commit_q;
  assign bus.ertn_commit_o    = ertn_commit_q;
  assign bus.excp_pc_o        = excp_pc_q;

endmodule
